// File: rtl/seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_scheduler
// Purpose  : 8-digit seven-segment scan controller (BLANK/SHOW time-multiplexing).
//            Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
// Revision : 1.0
// ============================================================================
module seg_scan_scheduler #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [3:0] digit_q,
    output logic [7:0] anode,
    output logic [2:0] digit_sel,
    output logic       frame_tick
);

    localparam int c_max_cnt = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_cnt);
    localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [2:0]           sel_d;
    logic                 tick_d;
    logic [7:0]           anode_d;
    logic [3:0]           digit_d;
    logic [3:0]           digits_q [8];
    logic [3:0]           digits_d [8];
    logic [7:0]           lit_mask;

    // Register file with this cycle's write folded in, so outputs see it at once.
    always_comb begin
        digits_d = digits_q;
        if (wr_en) begin
            digits_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        sel_d   = digit_sel;
        tick_d  = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sel_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end
                S_BLANK: begin
                    if (cnt_q == c_blank_last) begin
                        state_d = S_SHOW;
                        cnt_d   = '0;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == c_show_last) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        sel_d   = digit_sel + 3'd1;
                        tick_d  = (digit_sel == 3'd7);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sel_d   = 3'd0;
                end
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is lit if it or any more significant digit is non-zero; digit 0 always.
    always_comb begin
        logic above_nz;
        lit_mask = 8'hFF;
        above_nz = 1'b0;
        for (int n = 7; n >= 1; n--) begin
            above_nz    = above_nz | (digits_d[n] != 4'd0);
            lit_mask[n] = above_nz;
        end
        lit_mask[0] = 1'b1;
    end
`else
    always_comb begin
        lit_mask = 8'hFF;
    end
`endif

    always_comb begin
        anode_d = 8'hFF;
        if ((state_d == S_SHOW) && lit_mask[sel_d]) begin
            anode_d = ~(8'b1 << sel_d);
        end
        digit_d = (state_d == S_IDLE) ? 4'd0 : digits_d[sel_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_BLANK;
            cnt_q      <= '0;
            digit_sel  <= 3'd0;
            anode      <= 8'hFF;
            digit_q    <= 4'h0;
            frame_tick <= 1'b0;
            digits_q   <= '{default: 4'h0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_sel  <= sel_d;
            anode      <= anode_d;
            digit_q    <= digit_d;
            frame_tick <= tick_d;
            digits_q   <= digits_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_scheduler.sv
`default_nettype none
// Scoreboard bench for seg_scan_scheduler: a frame-position reference model
// predicts each cycle's outputs; a monitor pops and compares them.
module tb_seg_scan_scheduler;

    localparam int RD    = 4;
    localparam int BC    = 2;
    localparam int DPER  = RD + BC;
    localparam int FPER  = 8 * DPER;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] digit_q;
    logic [7:0] anode;
    logic [2:0] digit_sel;
    logic       frame_tick;

    seg_scan_scheduler #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .digit_q   (digit_q),
        .anode     (anode),
        .digit_sel (digit_sel),
        .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [7:0] anode;
        logic [3:0] dq;
        logic [2:0] sel;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: idle flag, cycles since scan start, digit contents.
    bit         m_idle;
    int         m_pos;
    logic [3:0] mem [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t e;
        int   sel;
        int   phase;
        bit   lit;
        e.anode = 8'hFF;
        e.dq    = 4'd0;
        e.sel   = 3'd0;
        e.tick  = 1'b0;
        if (!m_idle) begin
            sel   = (m_pos / DPER) % 8;
            phase = m_pos % DPER;
            lit   = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            if (sel != 0) begin
                lit = 1'b0;
                for (int k = sel; k < 8; k++) if (mem[k] != 0) lit = 1'b1;
            end
`endif
            if (phase >= BC && lit) e.anode = ~(8'b1 << sel);
            e.dq   = mem[sel];
            e.sel  = 3'(sel);
            e.tick = (m_pos > 0) && (m_pos % FPER == 0);
        end
        return e;
    endfunction

    task automatic step(input bit r, input bit en, input bit we,
                        input logic [2:0] a, input logic [3:0] d);
        @(negedge clk);
        reset   = r;
        enable  = en;
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        if (r) begin
            m_idle = 1'b0;
            m_pos  = 0;
            for (int k = 0; k < 8; k++) mem[k] = 4'd0;
        end else begin
            if (we) mem[a] = d;
            if (!en) begin
                m_idle = 1'b1;
            end else if (m_idle) begin
                m_idle = 1'b0;
                m_pos  = 0;
            end else begin
                m_pos++;
            end
        end
        sb.push_back(model_out());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 3'd0, 4'd0);
    endtask

    // Advance until the model's current cycle is at the given frame position.
    task automatic run_to(input int fpos);
        int guard = 0;
        while ((m_idle || (m_pos % FPER) != fpos) && guard < 4 * FPER) begin
            step(0, 1, 0, 3'd0, 4'd0);
            guard++;
        end
        if (guard >= 4 * FPER) begin
            total++;
            bad++;
            $display("FAIL run_to timeout: pos=%0d wanted %0d", m_pos, fpos);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("anode",      anode,             e.anode);
                chk("digit_q",    {4'd0, digit_q},   {4'd0, e.dq});
                chk("digit_sel",  {5'd0, digit_sel}, {5'd0, e.sel});
                chk("frame_tick", {7'd0, frame_tick}, {7'd0, e.tick});
            end
        end
    end

    initial begin : stim
        reset   = 1'b0;
        enable  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 4'd0;
        m_idle  = 1'b1;
        m_pos   = 0;
        for (int k = 0; k < 8; k++) mem[k] = 4'd0;

        step(1, 0, 0, 3'd0, 4'd0);
        step(1, 1, 1, 3'd4, 4'd6);
        run(2 * FPER + 5);

        step(0, 1, 1, 3'd3, 4'd9);
        step(0, 1, 1, 3'd0, 4'd5);
        run(FPER + 3);

        run_to(2 * DPER + BC + 1);
        step(0, 1, 1, 3'd2, 4'd7);
        run(DPER);

        run_to(5 * DPER + BC + 1);
        step(0, 0, 0, 3'd0, 4'd0);
        step(0, 0, 1, 3'd6, 4'd2);
        step(0, 1, 0, 3'd0, 4'd0);
        run(FPER + 4);

        for (int k = 7; k >= 0; k--) begin
            logic [3:0] v;
            v = (k == 2) ? 4'd1 : ((k == 0) ? 4'd3 : 4'd0);
            step(0, 1, 1, 3'(k), v);
        end
        run(FPER + 2);

        step(0, 1, 1, 3'd7, 4'd8);
        step(0, 1, 1, 3'd5, 4'd10);
        run(20);
        step(1, 1, 1, 3'd1, 4'd4);
        run(FPER + 2);

        for (int i = 0; i < 1500; i++) begin
            bit r, en, we;
            r  = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 29) != 0);
            we = ($urandom_range(0, 3) == 0);
            step(r, en, we, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end
        run(10);

        @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
